// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : assembles a big-endian byte stream into 32-bit words, writes
//               them to instruction memory and releases the core on HALT_WORD
// Revision    : 1.0
// ============================================================================
module imem_loader #(
  parameter int          ADDR_W    = 13,
  parameter logic [31:0] HALT_WORD = 32'hffffffff
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic              core_run,
  output logic              load_done,
  output logic              overflow_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_partial;
  logic [ADDR_W-1:0] r_addr;

  logic              w_accept;
  logic [31:0]       w_word;

  assign byte_ready = (r_state == S_LOAD);
  assign w_accept   = byte_valid & byte_ready;
  assign w_word     = {r_partial, byte_in};

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_partial    <= 24'd0;
      r_addr       <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      word_count   <= '0;
      checksum     <= 32'd0;
      core_run     <= 1'b0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_addr     <= '0;
            word_count <= '0;
            checksum   <= 32'd0;
            r_byte_cnt <= 2'd0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_partial  <= {r_partial[15:0], byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= r_addr;
              imem_wdata <= w_word;
              word_count <= word_count + (ADDR_W+1)'(1);
              checksum   <= checksum + w_word;
              r_addr     <= r_addr + ADDR_W'(1);
            end
          end
          // Terminate on the cycle of the write; halt wins over a full memory.
          if (imem_we) begin
            if (imem_wdata == HALT_WORD) begin
              r_state   <= S_DONE;
              load_done <= 1'b1;
              core_run  <= 1'b1;
            end else if (imem_addr == C_LAST_ADDR) begin
              r_state      <= S_ERR;
              overflow_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : table vectors, hand sequences and randomized streams
// Revision       : 1.0
// ============================================================================
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: full-size memory
  logic        rst_a = 1'b1, start_a = 1'b0, bv_a = 1'b0;
  logic [7:0]  bin_a = 8'd0;
  logic        br_a, we_a, run_a, ld_a, err_a;
  logic [12:0] addr_a;
  logic [31:0] wd_a, cs_a;
  logic [13:0] wc_a;

  // DUT B: eight-word memory for overflow corners
  logic        rst_b = 1'b1, start_b = 1'b0, bv_b = 1'b0;
  logic [7:0]  bin_b = 8'd0;
  logic        br_b, we_b, run_b, ld_b, err_b;
  logic [2:0]  addr_b;
  logic [31:0] wd_b, cs_b;
  logic [3:0]  wc_b;

  imem_loader u_dut_a (
    .clk1(clk), .rst(rst_a), .start(start_a), .byte_in(bin_a), .byte_valid(bv_a),
    .byte_ready(br_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .word_count(wc_a), .checksum(cs_a), .core_run(run_a), .load_done(ld_a),
    .overflow_err(err_a)
  );

  imem_loader #(.ADDR_W(3)) u_dut_b (
    .clk1(clk), .rst(rst_b), .start(start_b), .byte_in(bin_b), .byte_valid(bv_b),
    .byte_ready(br_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .word_count(wc_b), .checksum(cs_b), .core_run(run_b), .load_done(ld_b),
    .overflow_err(err_b)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_data[$], wb_data[$], exp_q[$], stream_q[$];
  int          wa_addr[$], wb_addr[$];
  int          ld_a_cnt = 0, ld_b_cnt = 0;

  always @(negedge clk) begin
    if (we_a) begin wa_addr.push_back(int'(addr_a)); wa_data.push_back(wd_a); end
    if (we_b) begin wb_addr.push_back(int'(addr_b)); wb_data.push_back(wd_b); end
    if (ld_a) ld_a_cnt++;
    if (ld_b) ld_b_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string tag, input bit use_b);
    int n;
    n = use_b ? wb_data.size() : wa_data.size();
    chk({tag, "_nwrites"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(use_b ? wb_addr[i] : wa_addr[i]), 64'(i));
      chk({tag, "_data"}, use_b ? 64'(wb_data[i]) : 64'(wa_data[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1; start_a = 1'b0; bv_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    wa_data.delete(); wa_addr.delete(); ld_a_cnt = 0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; start_b = 1'b0; bv_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    wb_data.delete(); wb_addr.delete(); ld_b_cnt = 0;
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
  endtask

  task automatic start_pulse_b();
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
  endtask

  task automatic send_byte_a(input logic [7:0] b, input int gap);
    bv_a = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bv_a = 1'b1; bin_a = b;
    @(posedge clk); #1;
    bv_a = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b, input int gap);
    bv_b = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bv_b = 1'b1; bin_b = b;
    @(posedge clk); #1;
    bv_b = 1'b0;
  endtask

  task automatic send_word_a(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte_a(w[31-8*j -: 8], 0);
  endtask

  task automatic send_stream_b(input bit rnd_gaps);
    logic [31:0] w;
    for (int i = 0; i < stream_q.size(); i++) begin
      w = stream_q[i];
      for (int j = 0; j < 4; j++)
        send_byte_b(w[31-8*j -: 8], rnd_gaps ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  // Loader semantics: words land at consecutive addresses until the halt word
  // is written or all eight locations are used.
  task automatic model_b(output bit halted, output bit ovf, output logic [31:0] sum);
    halted = 1'b0; ovf = 1'b0; sum = 32'd0;
    exp_q.delete();
    foreach (stream_q[i]) begin
      if (halted || ovf) break;
      exp_q.push_back(stream_q[i]);
      sum = sum + stream_q[i];
      if (stream_q[i] == 32'hffffffff) halted = 1'b1;
      else if (exp_q.size() == 8) ovf = 1'b1;
    end
  endtask

  task automatic check_final_b(input string tag, input bit halted, input bit ovf,
                               input logic [31:0] sum);
    check_writes(tag, 1'b1);
    chk({tag, "_wc"}, 64'(wc_b), 64'(exp_q.size()));
    chk({tag, "_cs"}, 64'(cs_b), 64'(sum));
    chk({tag, "_run"}, 64'(run_b), 64'(halted));
    chk({tag, "_err"}, 64'(err_b), 64'(ovf));
    chk({tag, "_ready"}, 64'(br_b), 64'(!(halted || ovf)));
    chk({tag, "_ldcnt"}, 64'(ld_b_cnt), 64'(halted));
  endtask

  typedef struct packed {
    logic [0:3][31:0] w;
    int               nw;
    int               gap_at;
    int               gap_len;
    logic [13:0]      exp_wc;
    logic [31:0]      exp_cs;
  } vec_t;

  vec_t tbl[5];

  initial begin
    vec_t        e;
    int          k;
    bit          halted, ovf;
    logic [31:0] sum, w;
    int          n, hpos;

    tbl[0] = '{{32'h20080005, 32'h0, 32'hffffffff, 32'h0}, 3, -1, 0, 14'd3, 32'h20080004};
    tbl[1] = '{{32'h20080005, 32'h0, 32'hffffffff, 32'h0}, 3,  2, 7, 14'd3, 32'h20080004};
    tbl[2] = '{{32'h12345678, 32'hffffffff, 32'h0, 32'h0}, 2, -1, 0, 14'd2, 32'h12345677};
    tbl[3] = '{{32'hffffffff, 32'h0, 32'h0, 32'h0},        1,  1, 3, 14'd1, 32'hffffffff};
    tbl[4] = '{{32'h00000001, 32'h80000000, 32'h7fffffff, 32'hffffffff},
               4, 13, 3, 14'd4, 32'hffffffff};

    #1;
    chk("rst_ctl",  64'({br_a, we_a, run_a, ld_a, err_a}), 64'd0);
    chk("rst_addr", 64'({addr_a, wc_a}), 64'd0);
    chk("rst_data", {wd_a, cs_a}, 64'd0);

    // Table vectors on the full-size loader
    for (int t = 0; t < 5; t++) begin
      e = tbl[t];
      reset_a();
      start_pulse_a();
      k = 0;
      for (int i = 0; i < e.nw; i++)
        for (int j = 0; j < 4; j++) begin
          send_byte_a(e.w[i][31-8*j -: 8], (k == e.gap_at) ? e.gap_len : 0);
          k++;
        end
      @(negedge clk);
      chk("lat_we_n1",  64'(we_a), 64'd1);
      chk("lat_run_n1", 64'(run_a), 64'd0);
      @(negedge clk);
      chk("lat_run_n2", 64'(run_a), 64'd1);
      chk("lat_ld_n2",  64'(ld_a), 64'd1);
      chk("lat_we_n2",  64'(we_a), 64'd0);
      @(negedge clk);
      chk("ld_pulse_end", 64'(ld_a), 64'd0);
      exp_q.delete();
      for (int i = 0; i < e.nw; i++) exp_q.push_back(e.w[i]);
      check_writes("tbl", 1'b0);
      chk("tbl_wc", 64'(wc_a), 64'(e.exp_wc));
      chk("tbl_cs", 64'(cs_a), 64'(e.exp_cs));
      chk("tbl_err", 64'(err_a), 64'd0);
      chk("tbl_ready", 64'(br_a), 64'd0);
      chk("tbl_ldcnt", 64'(ld_a_cnt), 64'd1);
    end

    // Asynchronous reset in the middle of the second word
    reset_a();
    start_pulse_a();
    send_word_a(32'h20080005);
    send_byte_a(8'h00, 0);
    send_byte_a(8'h00, 0);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_count", 64'({addr_a, wc_a}), 64'd0);
    chk("arst_data",  {wd_a, cs_a}, 64'd0);
    chk("arst_ready", 64'(br_a), 64'd0);
    reset_a();
    start_pulse_a();
    send_word_a(32'h12345678);
    send_word_a(32'hffffffff);
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hffffffff);
    check_writes("arst_reload", 1'b0);
    chk("arst_reload_wc", 64'(wc_a), 64'd2);
    chk("arst_reload_run", 64'(run_a), 64'd1);

    // Bytes before start, start during LOAD and DONE
    reset_a();
    send_word_a(32'hdeadbeef);
    @(negedge clk);
    chk("idle_ready", 64'(br_a), 64'd0);
    chk("idle_writes", 64'(wa_data.size()), 64'd0);
    #1;
    start_pulse_a();
    send_byte_a(8'h12, 0);
    send_byte_a(8'h34, 0);
    start_pulse_a();
    send_byte_a(8'h56, 0);
    send_byte_a(8'h78, 0);
    send_word_a(32'hffffffff);
    repeat (3) begin @(posedge clk); #1; end
    start_pulse_a();
    send_word_a(32'haabbccdd);
    repeat (3) @(negedge clk);
    check_writes("start_ign", 1'b0);
    chk("start_ign_wc", 64'(wc_a), 64'd2);
    chk("start_ign_run", 64'(run_a), 64'd1);
    chk("start_ign_ready", 64'(br_a), 64'd0);
    chk("start_ign_ldcnt", 64'(ld_a_cnt), 64'd1);

    // Eight-word memory filled without halt, ninth word offered
    reset_b();
    start_pulse_b();
    stream_q.delete();
    repeat (9) stream_q.push_back(32'h00000001);
    send_stream_b(1'b0);
    repeat (4) @(negedge clk);
    exp_q.delete();
    repeat (8) exp_q.push_back(32'h00000001);
    check_final_b("ovf", 1'b0, 1'b1, 32'd8);
    chk("ovf_wc8", 64'(wc_b), 64'd8);

    // Halt word at the last address
    reset_b();
    start_pulse_b();
    stream_q.delete();
    repeat (7) stream_q.push_back(32'h00000001);
    stream_q.push_back(32'hffffffff);
    send_stream_b(1'b0);
    repeat (4) @(negedge clk);
    model_b(halted, ovf, sum);
    check_final_b("halt_last", halted, ovf, sum);
    chk("halt_last_cs", 64'(cs_b), 64'h6);
    chk("halt_last_err", 64'(err_b), 64'd0);

    // Randomized streams against the model
    for (int r = 0; r < 30; r++) begin
      reset_b();
      start_pulse_b();
      stream_q.delete();
      n    = int'($urandom_range(1, 11));
      hpos = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) begin
        w = $urandom();
        if (w == 32'hffffffff) w = 32'h0;
        stream_q.push_back((i == hpos) ? 32'hffffffff : w);
      end
      send_stream_b(1'b1);
      repeat (4) @(negedge clk);
      model_b(halted, ovf, sum);
      check_final_b("rnd", halted, ovf, sum);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader upstream of pipelined_mips.
- Accepts a byte stream of big-endian machine code and assembles 32-bit words.
- Writes each word into instruction memory from word address 0, stopping at the halt word 32'hffffffff.
- Raises core_run when loading is complete; core_run gates the core's halted/pc-release so execution starts at pc=0 with a fully loaded I_memory.

Parameters:
- ADDR_W, 13, instruction-memory word-address width (8192 words).
- HALT_WORD, 32'hffffffff, terminator word; it is written, then loading ends.

Ports:
- clk1  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled word.
- word_count  out  ADDR_W+1  words written in the current/last load.
- checksum  out  32  mod-2^32 sum of all words written, HALT_WORD included.
- core_run  out  1  high = core may execute.
- load_done  out  1  one-cycle pulse when the HALT_WORD write completes.
- overflow_err  out  1  sticky; memory filled without HALT_WORD.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; byte counter, word address, partial word, word_count and checksum cleared.
- Reset mid-load discards the partial word; memory already written is left untouched.
- States: IDLE, LOAD, DONE, ERR.
- IDLE:
  - byte_ready=0.
  - start=1 → LOAD. On entry, addr, word_count, checksum and byte counter are cleared.
- LOAD:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte order: first byte is bits [31:24], fourth byte is [7:0].
  - On the cycle the 4th byte is accepted, the word is registered. On the next cycle: imem_we=1, imem_addr=current addr, imem_wdata=word. word_count and checksum update in that same cycle, and addr increments after the write.
  - Bytes continue to be accepted during the write cycle; there are no bubbles.
  - If the written word == HALT_WORD: go to DONE after the write. byte_ready drops in the cycle after the write. Further bytes are ignored.
  - If the word just written was at addr 2^ADDR_W-1 and was not HALT_WORD: go to ERR.
  - start while in LOAD is ignored.
  - byte_valid gaps of any length are allowed; the partial word is held.
- DONE:
  - load_done pulses for exactly one cycle on entry (the cycle after the HALT write).
  - core_run=1 from that same cycle and held until rst.
  - byte_ready=0; start is ignored.
- ERR: overflow_err=1 and byte_ready=0, held until rst; core_run stays 0.
- Latency: the HALT_WORD's 4th byte is accepted at cycle N; imem_we occurs at N+1; core_run=1 and load_done at N+2.
- A HALT_WORD that lands at the last address → DONE, not ERR (halt takes priority).
- word_count saturates naturally at 2^ADDR_W; its ADDR_W+1 width avoids wrap.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Test Plan:
- 3 words: bytes 20,08,00,05 / 00,00,00,00 / ff,ff,ff,ff after start → writes 32'h20080005@0, 0@1, ffffffff@2; word_count=3; checksum=32'h20080004; core_run=1 two cycles after the last byte; load_done a single pulse.
- Same stream with byte_valid low for 7 cycles between bytes 2 and 3 → identical writes and addresses; no spurious imem_we.
- rst asserted after 6 bytes → outputs 0 immediately (asynchronous). Then start plus stream 12,34,56,78,ff,ff,ff,ff → 32'h12345678@0, ffffffff@1.
- Bytes before start, and start pulses during LOAD/DONE → no byte_ready, no writes, no restart.
- ADDR_W=3, eight words of 32'h00000001 → writes at 0..7, overflow_err=1, core_run=0, checksum=8. A ninth word is not written.
- ADDR_W=3, seven words then HALT_WORD at address 7 → DONE, overflow_err=0, word_count=8.
